// File: rtl/train_pkg.sv
// Shared constants and types for the train-track controller front end.
package train_pkg;

    localparam int NUM_SENSORS      = 4;
    localparam int DEB_CYCLES_DEF   = 4;
    localparam int STUCK_CYCLES_DEF = 1000;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        RISING  = 2'd1,
        HIGH    = 2'd2,
        FALLING = 2'd3
    } deb_state_t;

endpackage

// File: rtl/sensor_debounce_ch.sv
// One sensor channel: 2-flop synchronizer, debounce FSM, rise pulse and stuck-high monitor.
// Stuck monitor is present only when SENSOR_STUCK_DETECT_EN is defined.
module sensor_debounce_ch
    import train_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic Clock,
    input  logic RESET,
    input  logic i_raw,
    input  logic i_clr_fault,
    output logic o_sr,
    output logic o_rise,
    output logic o_fault
);

    // The entry cycle into RISING/FALLING already counts as the first sample.
    localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       r_s1;
    logic       r_s2;
    deb_state_t r_state;
    deb_state_t w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_sr;
    logic       r_rise;
    logic       w_commit_rise;
    logic       w_sr_nxt;

    always_ff @(posedge Clock or negedge RESET) begin
        if (!RESET) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            LOW: begin
                if (r_s2) begin
                    w_state_nxt = RISING;
                    w_cnt_nxt   = 4'd1;
                end
            end
            RISING: begin
                if (!r_s2) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt >= DEB_LAST) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = FALLING;
                    w_cnt_nxt   = 4'd1;
                end
            end
            FALLING: begin
                if (r_s2) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt >= DEB_LAST) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = LOW;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign w_commit_rise = (r_state == RISING) && (w_state_nxt == HIGH);
    assign w_sr_nxt      = (w_state_nxt == HIGH) || (w_state_nxt == FALLING);

    // Outputs are registered from the next state so they line up with the state change.
    always_ff @(posedge Clock or negedge RESET) begin
        if (!RESET) begin
            r_state <= LOW;
            r_cnt   <= 4'd0;
            r_sr    <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sr    <= w_sr_nxt;
            r_rise  <= w_commit_rise;
        end
    end

    assign o_sr   = r_sr;
    assign o_rise = r_rise;

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int                STK_W   = $clog2(STUCK_CYCLES + 1);
    localparam logic [STK_W-1:0]  STK_MAX = STK_W'(STUCK_CYCLES);

    logic [STK_W-1:0] r_stk;
    logic [STK_W-1:0] w_stk_nxt;
    logic             r_fault;

    always_comb begin
        w_stk_nxt = '0;
        if (r_sr) begin
            w_stk_nxt = (r_stk == STK_MAX) ? r_stk : r_stk + 1'b1;
        end
    end

    // Clear beats set; a saturated counter re-raises the flag on the following cycle.
    always_ff @(posedge Clock or negedge RESET) begin
        if (!RESET) begin
            r_stk   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_stk <= w_stk_nxt;
            if (i_clr_fault) begin
                r_fault <= 1'b0;
            end else if (w_stk_nxt == STK_MAX) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign o_fault = r_fault;
`else
    logic w_unused;
    assign w_unused = i_clr_fault | (STUCK_CYCLES < 2);
    assign o_fault  = 1'b0;
`endif

endmodule

// File: rtl/sensor_conditioner.sv
// Four independent debounced track-sensor channels feeding the track-state FSM.
// Stuck-sensor FAULT logic is enabled by defining SENSOR_STUCK_DETECT_EN.
module sensor_conditioner
    import train_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEF,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
    input  logic       Clock,
    input  logic       RESET,
    input  logic [4:1] SR_RAW,
    input  logic       CLR_FAULT,
    output logic [4:1] SR,
    output logic [4:1] SR_RISE,
    output logic [4:1] FAULT
);

    for (genvar gi = 1; gi <= NUM_SENSORS; gi++) begin : g_ch
        sensor_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .STUCK_CYCLES   (STUCK_CYCLES)
        ) u_ch (
            .Clock      (Clock),
            .RESET      (RESET),
            .i_raw      (SR_RAW[gi]),
            .i_clr_fault(CLR_FAULT),
            .o_sr       (SR[gi]),
            .o_rise     (SR_RISE[gi]),
            .o_fault    (FAULT[gi])
        );
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner: directed per-cycle vectors with hand-computed outputs.
module tb_sensor_conditioner;

    logic       Clock;
    logic       RESET;
    logic       CLR_FAULT;
    logic [4:1] SR_RAW;
    logic [4:1] SR;
    logic [4:1] SR_RISE;
    logic [4:1] FAULT;

    typedef struct {
        logic [4:1] sr;
        logic [4:1] rise;
        logic [4:1] fault;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event ev_async;

`ifdef SENSOR_STUCK_DETECT_EN
    localparam logic [4:1] F3 = 4'b0100;
`else
    localparam logic [4:1] F3 = 4'b0000;
`endif

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .STUCK_CYCLES   (8)
    ) dut (
        .Clock    (Clock),
        .RESET    (RESET),
        .SR_RAW   (SR_RAW),
        .CLR_FAULT(CLR_FAULT),
        .SR       (SR),
        .SR_RISE  (SR_RISE),
        .FAULT    (FAULT)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic push_exp(input logic [4:1] esr, input logic [4:1] erise,
                            input logic [4:1] efault, input string nm);
        exp_t e;
        e.sr    = esr;
        e.rise  = erise;
        e.fault = efault;
        e.nm    = nm;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs; the expectation applies just after the next rising edge.
    task automatic cyc(input logic rstn, input logic [4:1] raw, input logic clr,
                       input logic [4:1] esr, input logic [4:1] erise,
                       input logic [4:1] efault, input string nm);
        @(negedge Clock);
        RESET     = rstn;
        SR_RAW    = raw;
        CLR_FAULT = clr;
        push_exp(esr, erise, efault, nm);
    endtask

    task automatic run(input int n, input logic rstn, input logic [4:1] raw, input logic clr,
                       input logic [4:1] esr, input logic [4:1] erise,
                       input logic [4:1] efault, input string nm);
        for (int i = 0; i < n; i++) begin
            cyc(rstn, raw, clr, esr, erise, efault, nm);
        end
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) return;
        e = sb.pop_front();
        checks++;
        if ({SR, SR_RISE, FAULT} !== {e.sr, e.rise, e.fault}) begin
            errors++;
            $display("FAIL %s @%0t: got SR=%b RISE=%b FAULT=%b, expected SR=%b RISE=%b FAULT=%b",
                     e.nm, $time, SR, SR_RISE, FAULT, e.sr, e.rise, e.fault);
        end
    endtask

    always @(posedge Clock) begin
        #1;
        compare();
    end

    always @(ev_async) begin
        compare();
    end

    initial begin
        RESET     = 1'b0;
        SR_RAW    = 4'b0000;
        CLR_FAULT = 1'b0;

        // Reset state, with raw inputs active
        run(3, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, "reset_state");

        // Clean rise on channel 1, held high through reset release
        run(5, 1'b1, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, "rise_wait");
        cyc(   1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000, "rise_commit");
        cyc(   1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, "rise_pulse_end");
        run(5, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, "fall_wait");
        cyc(   1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, "fall_commit");
        run(3, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, "idle1");

        // Bounce on channel 2
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, "bounce_hi");
            cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, "bounce_lo");
        end
        run(6, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, "bounce_settle");

        // Three samples high: one short of commit
        run(3, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, "short_pulse");
        run(8, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, "short_settle");

        // Simultaneous rise and release on all channels
        run(5, 1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, "sim_wait");
        cyc(   1'b1, 4'b1111, 1'b0, 4'b1111, 4'b1111, 4'b0000, "sim_commit");
        run(5, 1'b1, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'b0000, "sim_fall_wait");
        cyc(   1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, "sim_fall");
        run(3, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, "idle2");

        // Stuck sensor on channel 3
        run(5, 1'b1, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000, "stk_wait");
        cyc(   1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0100, 4'b0000, "stk_rise");
        run(7, 1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0000, "stk_count");
        run(2, 1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0000, F3,      "stk_fault");
        cyc(   1'b1, 4'b0100, 1'b1, 4'b0100, 4'b0000, 4'b0000, "stk_clr_wins");
        cyc(   1'b1, 4'b0100, 1'b0, 4'b0100, 4'b0000, F3,      "stk_reset_sat");
        run(5, 1'b1, 4'b0000, 1'b0, 4'b0100, 4'b0000, F3,      "stk_drop_wait");
        cyc(   1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, F3,      "stk_drop");
        run(2, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, F3,      "stk_sticky");
        cyc(   1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, "stk_clr");
        run(2, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, "stk_cleared");

        // Reset while channel 1 is HIGH and channel 2 is mid-RISING
        run(5, 1'b1, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, "mid_wait");
        cyc(   1'b1, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000, "mid_ch1_rise");
        run(4, 1'b1, 4'b0011, 1'b0, 4'b0001, 4'b0000, 4'b0000, "mid_ch2_rising");
        @(negedge Clock);
        RESET = 1'b0;
        #1;
        push_exp(4'b0000, 4'b0000, 4'b0000, "rst_async");
        -> ev_async;
        run(2, 1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 4'b0000, "rst_hold");
        run(5, 1'b1, 4'b0011, 1'b0, 4'b0000, 4'b0000, 4'b0000, "rerise_wait");
        cyc(   1'b1, 4'b0011, 1'b0, 4'b0011, 4'b0011, 4'b0000, "rerise_commit");
        cyc(   1'b1, 4'b0011, 1'b0, 4'b0011, 4'b0000, 4'b0000, "rerise_end");

        repeat (3) @(negedge Clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
